spi_slave_frontend: RTL and testbench
=====================================

# spi_slave_frontend

Serial front end of the SPI slave driver. It brings the asynchronous SPI pins (SCLK, CS_N, MOSI) into the system clock domain and detects the sample and drive edges. It deserialises MOSI into words and serialises transmit words onto MISO. Its `bit_en` pulse is the enable source for the downstream bit/byte counters; its `rx_data`/`rx_valid` output feeds the command decoder.

## Interface
- `DATA_W`, default 8: word length in bits, ≥ 2.
- `CPOL`, default 0: SCLK idle level.
- `CPHA`, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `MSB_FIRST`, default 1: bit order for both directions.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_sclk` in 1: SPI clock pin, asynchronous.
- `spi_cs_n` in 1: chip select pin, active-low, asynchronous.
- `spi_mosi` in 1: master-out data pin, asynchronous.
- `spi_miso` out 1: slave-out data.
- `spi_miso_oe` out 1: MISO output enable, 1 while the frame is active.
- `bit_en` out 1: one-cycle pulse per sample edge inside a frame.
- `rx_data` out DATA_W: last completed receive word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_data` in DATA_W: next transmit word, sampled when `tx_ack` is 1.
- `tx_ack` out 1: one-cycle pulse; `tx_data` was loaded this cycle.
- `frame_active` out 1: synchronised CS asserted.
- `frame_err` out 1: one-cycle pulse; CS rose mid-word.

## Operation
- Synchronisers: each of sclk, cs_n and mosi passes through 2 flops (s1, s2). A third flop (s3) on sclk and cs_n gives the previous value for edge detection.
- Leading edge = s2≠s3 with s2 = ~CPOL. Trailing edge = s2≠s3 with s2 = CPOL.
- Sample edge = leading if CPHA=0, else trailing. Drive edge = the opposite edge.
- Edges are honoured only when the state is ACTIVE.
- FSM IDLE:
  - `spi_miso_oe`=0, `spi_miso`=0, bit count 0.
  - On synchronised CS fall (s2=0, s3=1): go ACTIVE. If CPHA=0, also load `tx_data` into the tx shift register and pulse `tx_ack`.
- FSM ACTIVE, sample edge:
  - Shift s2 mosi into the rx shift register (MSB_FIRST: enters at LSB, shifts toward MSB).
  - Pulse `bit_en`.
  - Increment the bit count modulo DATA_W.
  - When the count wraps from DATA_W-1 to 0, register the full word into `rx_data` and pulse `rx_valid` next cycle.
- FSM ACTIVE, drive edge:
  - If bit count = 0: load `tx_data` and pulse `tx_ack`.
  - Otherwise: shift the tx register by one.
- `spi_miso` = tx register MSB (LSB if MSB_FIRST=0), registered. It is 0 when not ACTIVE.
- FSM ACTIVE, synchronised CS rise:
  - Go IDLE.
  - If bit count ≠ 0, pulse `frame_err`, discard the partial word, and do not pulse `rx_valid`.
  - Clear the bit count.
- Simultaneous CS rise and sample edge in the same cycle: the CS rise wins and the edge is ignored.
- Back-to-back words within one CS need no gap. The count wraps and the next drive edge reloads from `tx_data`.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `bit_en`=0, `rx_data`=0, `rx_valid`=0, `tx_ack`=0, `frame_active`=0, `frame_err`=0. State IDLE, all shift registers 0, synchronisers reset to idle levels (sclk=CPOL, cs_n=1).
- Pin edge to internal edge pulse: 2 clk cycles. `bit_en` asserts in the cycle s2 first shows the new level.
- Last sample edge to `rx_valid`: 1 clk cycle. `rx_data` is held stable until the next `rx_valid`.
- Drive edge to `spi_miso` change: 1 clk cycle after edge detection, 3 clk cycles from the pin.
- `tx_ack` and the tx register load happen in the same cycle. The upstream block must keep `tx_data` valid at all times while `frame_active`=1.
- `frame_active` follows synchronised cs_n (s2) registered: 3 cycles from the pin.
- Constraint: f_sclk ≤ f_clk/8. Each SCLK half period must be at least 4 clk cycles.
- Reset mid-frame: all outputs return to reset values immediately. After release, wait for a fresh CS fall; CS already low at release does not start a frame.

## Test plan
- Mode 0, DATA_W=8: CS low, master sends 0xA5 while `tx_data`=0x3C → `rx_valid` once with `rx_data`=0xA5; master receives 0x3C; 8 `bit_en` pulses; `tx_ack` at CS fall.
- Mode 3 (CPOL=1, CPHA=1): two back-to-back bytes 0x01, 0x80 with `tx_data` changed to 0xFF after the first `tx_ack` → `rx_valid` twice (0x01, 0x80); MISO carries the first word, then 0xFF; exactly 2 `tx_ack`.
- MSB_FIRST=0, mode 1: MOSI 0x96 → `rx_data`=0x96; MISO bit order LSB first for `tx_data`=0x0F.
- Abort: CS rises after 5 bits → `frame_err` pulse, no `rx_valid`, `spi_miso_oe`=0 within 3 cycles; next full frame receives correctly.
- `rst_n` pulsed low mid-word while CS stays low → outputs reset, no `rx_valid`; no activity until CS toggles high then low.
- SCLK at exactly clk/8 over 16 frames with random data → all words match, no missed `bit_en`.

Source files
------------

// File: rtl/spi_slave_frontend_if.sv
// rtl/spi_slave_frontend_if.sv - SPI pin and word-side signal bundle for spi_slave_frontend
interface spi_slave_frontend_if #(
  parameter int unsigned DATA_W = 8
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              bit_en;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;
  logic              frame_active;
  logic              frame_err;

  // Design side: consumes pins and transmit word, produces everything else
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_data,
    output spi_miso, spi_miso_oe, bit_en, rx_data, rx_valid, tx_ack,
           frame_active, frame_err
  );

  // Environment side: drives pins and transmit word
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_data,
    input  spi_miso, spi_miso_oe, bit_en, rx_data, rx_valid, tx_ack,
           frame_active, frame_err
  );
endinterface

// File: rtl/spi_slave_frontend.sv
// rtl/spi_slave_frontend.sv - SPI slave pin synchroniser, edge detector and word shifter
module spi_slave_frontend #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_slave_frontend_if.slave   bus
);

  localparam int unsigned CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic              sclk_s1, sclk_s2, sclk_s3;
  logic              cs_s1, cs_s2, cs_s3;
  logic              mosi_s1, mosi_s2;
  logic [1:0]        flush_cnt;
  logic              armed;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_word;
  logic              lead_edge, trail_edge, sample_edge, drive_edge;
  logic              cs_fall, cs_rise;
  logic              act, do_sample, do_drive, do_start, load_tx;
  logic              miso_next;

  // Two-flop synchronisers plus a history flop on sclk/cs_n; armed blocks a
  // frame start until cs_n has been seen high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1   <= CPOL;
      sclk_s2   <= CPOL;
      sclk_s3   <= CPOL;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_s3     <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      flush_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      sclk_s1 <= bus.spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= bus.spi_cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= bus.spi_mosi;
      mosi_s2 <= mosi_s1;
      if (flush_cnt != 2'd3) begin
        flush_cnt <= flush_cnt + 2'd1;
      end else if (cs_s2) begin
        armed <= 1'b1;
      end
    end
  end

  // Edge classification and per-cycle actions; a CS rise masks any SCLK edge
  always_comb begin
    lead_edge   = (sclk_s2 != sclk_s3) && (sclk_s2 == ~CPOL);
    trail_edge  = (sclk_s2 != sclk_s3) && (sclk_s2 == CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    drive_edge  = CPHA ? lead_edge : trail_edge;
    cs_fall     = armed && !cs_s2 && cs_s3;
    cs_rise     = cs_s2 && !cs_s3;
    act         = (state == ACTIVE) && !cs_rise;
    do_sample   = act && sample_edge;
    do_drive    = act && drive_edge;
    do_start    = (state == IDLE) && cs_fall;
    load_tx     = (do_start && (CPHA == 1'b0)) || (do_drive && (bit_cnt == '0));
    rx_word     = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_s2}
                            : {mosi_s2, rx_sr[DATA_W-1:1]};
  end

  // Next transmit shift value; MISO is registered from it so the pin moves
  // one cycle after the drive edge is detected
  always_comb begin
    tx_next = tx_sr;
    if ((state == ACTIVE) && cs_rise) begin
      tx_next = '0;
    end else if (load_tx) begin
      tx_next = bus.tx_data;
    end else if (do_drive) begin
      tx_next = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
    end
    miso_next = MSB_FIRST ? tx_next[DATA_W-1] : tx_next[0];
  end

  assign bus.bit_en = do_sample;
  assign bus.tx_ack = load_tx;

  // Frame FSM with registered pin and word outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      rx_sr            <= '0;
      tx_sr            <= '0;
      bus.rx_data      <= '0;
      bus.rx_valid     <= 1'b0;
      bus.spi_miso     <= 1'b0;
      bus.spi_miso_oe  <= 1'b0;
      bus.frame_active <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      tx_sr         <= tx_next;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (cs_fall) begin
            state            <= ACTIVE;
            bus.spi_miso_oe  <= 1'b1;
            bus.frame_active <= 1'b1;
            bus.spi_miso     <= miso_next;
          end else begin
            bus.spi_miso_oe  <= 1'b0;
            bus.frame_active <= 1'b0;
            bus.spi_miso     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state            <= IDLE;
            bus.spi_miso_oe  <= 1'b0;
            bus.frame_active <= 1'b0;
            bus.spi_miso     <= 1'b0;
            bus.frame_err    <= (bit_cnt != '0);
            bit_cnt          <= '0;
            rx_sr            <= '0;
          end else begin
            bus.spi_miso <= miso_next;
            if (do_sample) begin
              rx_sr <= rx_word;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt      <= '0;
                bus.rx_data  <= rx_word;
                bus.rx_valid <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb/tb_spi_slave_frontend.sv - scoreboard bench for spi_slave_frontend in three SPI modes
module tb_spi_slave_frontend;

  typedef struct packed {
    logic [1:0] k;
    logic [7:0] d;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       sclk_d [3];
  logic       cs_d   [3];
  logic       mosi_d [3];
  logic [7:0] txd    [3];

  logic       rxv  [3];
  logic [7:0] rxd  [3];
  logic       ben  [3];
  logic       ack  [3];
  logic       ferr [3];
  logic       miso [3];
  logic       oe   [3];
  logic       fact [3];

  int ben_cnt [3];
  int ack_cnt [3];
  int rx_cnt  [3];
  int ferr_cnt[3];

  int test_cnt;
  int fail_cnt;

  exp_t exp_q[$];
  exp_t e;

  logic [7:0] mo_buf[4];
  logic [7:0] mi_buf[4];
  int   acks0;
  logic st_ok;
  logic oe_aft;
  int   r0, b0, a0, f0;
  int   ben_rel, rx_rel;
  int   wait_n;
  logic [7:0] rv, tv;

  spi_slave_frontend_if #(.DATA_W(8)) if0 ();
  spi_slave_frontend_if #(.DATA_W(8)) if1 ();
  spi_slave_frontend_if #(.DATA_W(8)) if2 ();

  spi_slave_frontend #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_mode0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  spi_slave_frontend #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_mode3 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  spi_slave_frontend #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_mode1_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.spi_sclk = sclk_d[0];
  assign if0.spi_cs_n = cs_d[0];
  assign if0.spi_mosi = mosi_d[0];
  assign if0.tx_data  = txd[0];
  assign if1.spi_sclk = sclk_d[1];
  assign if1.spi_cs_n = cs_d[1];
  assign if1.spi_mosi = mosi_d[1];
  assign if1.tx_data  = txd[1];
  assign if2.spi_sclk = sclk_d[2];
  assign if2.spi_cs_n = cs_d[2];
  assign if2.spi_mosi = mosi_d[2];
  assign if2.tx_data  = txd[2];

  assign rxv[0] = if0.rx_valid;  assign rxv[1] = if1.rx_valid;  assign rxv[2] = if2.rx_valid;
  assign rxd[0] = if0.rx_data;   assign rxd[1] = if1.rx_data;   assign rxd[2] = if2.rx_data;
  assign ben[0] = if0.bit_en;    assign ben[1] = if1.bit_en;    assign ben[2] = if2.bit_en;
  assign ack[0] = if0.tx_ack;    assign ack[1] = if1.tx_ack;    assign ack[2] = if2.tx_ack;
  assign ferr[0] = if0.frame_err; assign ferr[1] = if1.frame_err; assign ferr[2] = if2.frame_err;
  assign miso[0] = if0.spi_miso; assign miso[1] = if1.spi_miso; assign miso[2] = if2.spi_miso;
  assign oe[0] = if0.spi_miso_oe; assign oe[1] = if1.spi_miso_oe; assign oe[2] = if2.spi_miso_oe;
  assign fact[0] = if0.frame_active; assign fact[1] = if1.frame_active; assign fact[2] = if2.frame_active;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard pop on every rx_valid
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ben[k])  ben_cnt[k]++;
      if (ack[k])  ack_cnt[k]++;
      if (ferr[k]) ferr_cnt[k]++;
      if (rxv[k]) begin
        rx_cnt[k]++;
        if (exp_q.size() == 0) begin
          check("rx_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", {k[1:0], rxd[k]}, {e.k, e.d});
        end
      end
    end
  end

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    exp_t x;
    x.k = k;
    x.d = d;
    exp_q.push_back(x);
  endtask

  task automatic snap(input int k);
    r0 = rx_cnt[k];
    b0 = ben_cnt[k];
    a0 = ack_cnt[k];
    f0 = ferr_cnt[k];
  endtask

  // SPI master: sends mo_buf, collects MISO into mi_buf, nbits total
  task automatic xfer(input int k, input bit cpol, input bit cpha, input bit lsb,
                      input int nbits, input int h);
    int         a_start;
    logic [1:0] w;
    logic [2:0] idx;
    for (int i = 0; i < 4; i++) mi_buf[i] = 8'h00;
    @(negedge clk);
    cs_d[k] = 1'b0;
    a_start = ack_cnt[k];
    repeat (8) @(negedge clk);
    acks0 = ack_cnt[k] - a_start;
    st_ok = fact[k] & oe[k];
    for (int n = 0; n < nbits; n++) begin
      w   = 2'(n / 8);
      idx = lsb ? 3'(n % 8) : 3'(7 - (n % 8));
      if (!cpha) mosi_d[k] = mo_buf[w][idx];
      repeat (h) @(negedge clk);
      sclk_d[k] = ~cpol;
      if (!cpha) mi_buf[w][idx] = miso[k];
      else       mosi_d[k] = mo_buf[w][idx];
      repeat (h) @(negedge clk);
      sclk_d[k] = cpol;
      if (cpha) mi_buf[w][idx] = miso[k];
    end
    repeat (h) @(negedge clk);
    cs_d[k] = 1'b1;
    repeat (3) @(negedge clk);
    oe_aft = oe[k];
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got 0x0, expected 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    test_cnt = 0;
    fail_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      ben_cnt[k] = 0; ack_cnt[k] = 0; rx_cnt[k] = 0; ferr_cnt[k] = 0;
      cs_d[k] = 1'b1; mosi_d[k] = 1'b0; txd[k] = 8'h00;
    end
    sclk_d[0] = 1'b0; sclk_d[1] = 1'b1; sclk_d[2] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    for (int k = 0; k < 3; k++) begin
      check("reset_miso", miso[k], 0);
      check("reset_oe", oe[k], 0);
      check("reset_rx_valid", rxv[k], 0);
      check("reset_rx_data", rxd[k], 0);
      check("reset_frame_active", fact[k], 0);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 0: 0xA5 in, 0x3C out
    txd[0] = 8'h3C; mo_buf[0] = 8'hA5; push(2'd0, 8'hA5); snap(0);
    xfer(0, 1'b0, 1'b0, 1'b0, 8, 5);
    check("m0_frame_started", st_ok, 1);
    check("m0_ack_at_cs_fall", acks0, 1);
    check("m0_miso_word", mi_buf[0], 8'h3C);
    check("m0_bit_en", ben_cnt[0] - b0, 8);
    check("m0_rx_count", rx_cnt[0] - r0, 1);
    check("m0_ack_total", ack_cnt[0] - a0, 2);
    check("m0_frame_err", ferr_cnt[0] - f0, 0);
    check("m0_oe_after_cs", oe_aft, 0);

    // Mode 3: back-to-back 0x01, 0x80; tx_data switched to 0xFF after first ack
    txd[1] = 8'h5A; mo_buf[0] = 8'h01; mo_buf[1] = 8'h80;
    push(2'd1, 8'h01); push(2'd1, 8'h80); snap(1);
    fork
      xfer(1, 1'b1, 1'b1, 1'b0, 16, 5);
      begin
        wait_n = 0;
        while ((ack_cnt[1] == a0) && (wait_n < 400)) begin
          @(negedge clk);
          wait_n++;
        end
        check("m3_first_ack_seen", ack_cnt[1] - a0, 1);
        txd[1] = 8'hFF;
      end
    join
    check("m3_miso_word0", mi_buf[0], 8'h5A);
    check("m3_miso_word1", mi_buf[1], 8'hFF);
    check("m3_ack_total", ack_cnt[1] - a0, 2);
    check("m3_rx_count", rx_cnt[1] - r0, 2);
    check("m3_bit_en", ben_cnt[1] - b0, 16);

    // Mode 1, LSB first: 0x96 in, 0x0F out
    txd[2] = 8'h0F; mo_buf[0] = 8'h96; push(2'd2, 8'h96); snap(2);
    xfer(2, 1'b0, 1'b1, 1'b1, 8, 5);
    check("lsb_miso_word", mi_buf[0], 8'h0F);
    check("lsb_rx_count", rx_cnt[2] - r0, 1);
    check("lsb_ack_total", ack_cnt[2] - a0, 1);

    // Abort after 5 bits, then a clean frame
    txd[0] = 8'h81; mo_buf[0] = 8'hFF; snap(0);
    xfer(0, 1'b0, 1'b0, 1'b0, 5, 5);
    check("abort_frame_err", ferr_cnt[0] - f0, 1);
    check("abort_no_rx", rx_cnt[0] - r0, 0);
    check("abort_oe_within_3", oe_aft, 0);
    check("abort_bit_en", ben_cnt[0] - b0, 5);
    mo_buf[0] = 8'hC3; push(2'd0, 8'hC3); snap(0);
    xfer(0, 1'b0, 1'b0, 1'b0, 8, 5);
    check("after_abort_miso", mi_buf[0], 8'h81);
    check("after_abort_rx", rx_cnt[0] - r0, 1);

    // Reset pulse mid-word with CS held low
    txd[0] = 8'hE7; mo_buf[0] = 8'h5A; snap(0);
    fork
      xfer(0, 1'b0, 1'b0, 1'b0, 8, 5);
      begin
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_oe", oe[0], 0);
        check("midrst_frame_active", fact[0], 0);
        check("midrst_miso", miso[0], 0);
        check("midrst_rx_data", rxd[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ben_rel = ben_cnt[0];
        rx_rel  = rx_cnt[0];
      end
    join
    check("midrst_no_bit_en", ben_cnt[0] - ben_rel, 0);
    check("midrst_no_rx", rx_cnt[0] - rx_rel, 0);
    check("midrst_rx_data_held", rxd[0], 0);
    mo_buf[0] = 8'h3D; push(2'd0, 8'h3D); snap(0);
    xfer(0, 1'b0, 1'b0, 1'b0, 8, 5);
    check("after_rst_miso", mi_buf[0], 8'hE7);
    check("after_rst_rx", rx_cnt[0] - r0, 1);

    // 16 frames at SCLK = clk/8 with random words
    snap(0);
    for (int i = 0; i < 16; i++) begin
      rv = 8'($urandom_range(0, 255));
      tv = 8'($urandom_range(0, 255));
      txd[0] = tv; mo_buf[0] = rv; push(2'd0, rv);
      xfer(0, 1'b0, 1'b0, 1'b0, 8, 4);
      check("fast_miso_word", mi_buf[0], tv);
    end
    check("fast_bit_en", ben_cnt[0] - b0, 128);
    check("fast_rx_count", rx_cnt[0] - r0, 16);
    check("fast_frame_err", ferr_cnt[0] - f0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
